// File: rtl/bubble_sort_seq_pkg.sv
// Shared types for the sequential sort engine: FSM state encoding and
// a counter-width helper that never returns zero.
package bubble_sort_seq_pkg;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SORT   = 2'd1,
      ST_UNLOAD = 2'd2
   } state_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bubble_sort_seq_cmp_swap.sv
// Combinational compare-exchange: lo gets the smaller, hi the larger (unsigned).
// Equal inputs pass straight through, so equal elements never swap.
module cmp_swap #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   logic w_swap;

   assign w_swap = (a > b);
   assign lo     = w_swap ? b : a;
   assign hi     = w_swap ? a : b;

endmodule

// File: rtl/bubble_sort_seq.sv
// Sequential odd-even transposition sorter: loads DIM elements, runs DIM
// compare-exchange layers (one per clock), then streams them out ascending.
module bubble_sort_seq
   import bubble_sort_seq_pkg::*;
#(
   parameter int DIM   = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int            CW   = clog2_min1(DIM);
   localparam logic [CW-1:0] LAST = CW'(DIM - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_phase;
   logic [WIDTH-1:0] r_mem   [DIM];

   logic [WIDTH-1:0] w_lo    [DIM-1];
   logic [WIDTH-1:0] w_hi    [DIM-1];
   logic [WIDTH-1:0] w_layer [DIM];
   logic             w_in_xfer;
   logic             w_out_xfer;

   // Handshake: a beat moves on a rising edge only when valid and ready are
   // both high; valid never waits on ready, and an offered beat (data, last)
   // holds steady until it is taken.
   assign w_in_xfer  = in_valid  && in_ready;
   assign w_out_xfer = out_valid && out_ready;

   assign in_ready  = (r_state == ST_LOAD);
   assign out_valid = (r_state == ST_UNLOAD);
   assign busy      = (r_state != ST_LOAD);
   assign out_data  = out_valid ? r_mem[r_cnt] : '0;
   assign out_last  = out_valid && (r_cnt == LAST);
   assign dbg_state = r_state;

   for (genvar g = 0; g < DIM - 1; g++) begin : g_cs
      cmp_swap #(.WIDTH(WIDTH)) u_cs (
         .a  (r_mem[g]),
         .b  (r_mem[g+1]),
         .lo (w_lo[g]),
         .hi (w_hi[g])
      );
   end

   // Pair k is active when its parity matches the phase; active pairs are disjoint.
   always_comb begin
      for (int i = 0; i < DIM; i++) w_layer[i] = r_mem[i];
      for (int k = 0; k < DIM - 1; k++) begin
         if (k[0] == r_phase) begin
            w_layer[k]   = w_lo[k];
            w_layer[k+1] = w_hi[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_LOAD;
         r_cnt   <= '0;
         r_phase <= 1'b0;
         for (int i = 0; i < DIM; i++) r_mem[i] <= '0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_in_xfer) begin
                  r_mem[r_cnt] <= in_data;
                  if (r_cnt == LAST) begin
                     r_state <= ST_SORT;
                     r_cnt   <= '0;
                     r_phase <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            ST_SORT: begin
               r_mem   <= w_layer;
               r_phase <= ~r_phase;
               if (r_cnt == LAST) begin
                  r_state <= ST_UNLOAD;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_UNLOAD: begin
               if (w_out_xfer) begin
                  if (r_cnt == LAST) begin
                     r_state <= ST_LOAD;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_LOAD;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bubble_sort_seq.sv
// Directed bench for bubble_sort_seq (DIM=8, WIDTH=8): vector table plus
// hand-written stall, reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_bubble_sort_seq;

   localparam int DIM   = 8;
   localparam int WIDTH = 8;

   typedef struct packed {
      logic [7:0][7:0] din;
      logic [7:0][7:0] dout;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             busy;
   logic [1:0]       dbg_state;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] exp_q[$];
   int    out_idx = 0;
   int    n_in = 0;
   time   t_in = 0;
   time   t_first_valid = 0;
   time   t_out_last = 0;
   time   t_b_first = 0;
   vec_t  vecs [3];

   bubble_sort_seq #(.DIM(DIM), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0][7:0] pk8(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_data"},  32'(out_data),  32'd0);
      check({tag, "_out_last"},  32'(out_last),  32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_state"},     32'(dbg_state), 32'd0);
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send(input logic [7:0] v);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = v;
      while (!in_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready never rose for %0h", v);
      end
      @(posedge clk);
      t_in = $time;
      n_in++;
      if (n_in == DIM + 1) t_b_first = $time;
      @(negedge clk);
   endtask

   task automatic send_block(input logic [7:0][7:0] d);
      for (int i = 0; i < DIM; i++) send(d[i]);
      in_valid = 1'b0;
   endtask

   task automatic recv_n(input int n, input bit rnd, input bit strays);
      int   got = 0;
      int   guard = 0;
      logic held = 1'b0;
      logic [7:0] hd;
      logic hl;
      logic [7:0] exp;
      while (got < n && guard < 3000) begin
         if (guard != 0 || got != 0) @(negedge clk);
         guard++;
         if (held) begin
            check("hold_data", 32'(out_data), 32'(hd));
            check("hold_last", 32'(out_last), 32'(hl));
         end
         if (strays) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'hEE;
            if (busy) check("in_ready_low", 32'(in_ready), 32'd0);
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid) begin
            if (t_first_valid == 0) t_first_valid = $time;
            if (out_ready) begin
               exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
               check("out_data", 32'(out_data), 32'(exp));
               check("out_last", 32'(out_last), (out_idx % DIM == DIM - 1) ? 32'd1 : 32'd0);
               if (out_last && t_out_last == 0) t_out_last = $time;
               out_idx++;
               got++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               hd   = out_data;
               hl   = out_last;
            end
         end else begin
            held = 1'b0;
         end
      end
      if (guard >= 3000) begin
         checks++; errors++;
         $display("FAIL recv_timeout: got %0d of %0d outputs", got, n);
      end
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0][7:0] d);
      for (int i = 0; i < DIM; i++) exp_q.push_back(d[i]);
   endtask

   initial begin
      vecs[0].din  = pk8(8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12);
      vecs[0].dout = pk8(8'h09, 8'h0D, 8'h12, 8'h24, 8'h63, 8'h65, 8'h81, 8'h8D);
      vecs[1].din  = pk8(8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01);
      vecs[1].dout = pk8(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
      vecs[2].din  = pk8(8'hFF, 8'h00, 8'h55, 8'h55, 8'hFF, 8'h00, 8'h80, 8'h7F);
      vecs[2].dout = pk8(8'h00, 8'h00, 8'h55, 8'h55, 8'h7F, 8'h80, 8'hFF, 8'hFF);

      // Clock/reset
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      // Table vectors, no backpressure; first out_valid 8 edges after last input edge
      for (int v = 0; v < 3; v++) begin
         push_exp(vecs[v].dout);
         send_block(vecs[v].din);
         check("sort_busy", 32'(busy), 32'd1);
         check("sort_in_ready", 32'(in_ready), 32'd0);
         t_first_valid = 0;
         recv_n(DIM, 1'b0, 1'b0);
         check("latency_edges", 32'((t_first_valid - t_in - 5) / 10), 32'(DIM));
      end

      // Random backpressure with stray inputs during SORT/UNLOAD
      push_exp(vecs[0].dout);
      send_block(vecs[0].din);
      recv_n(DIM, 1'b1, 1'b1);
      check("stall_q_empty", 32'(exp_q.size()), 32'd0);

      // Reset after three loads
      send(8'h11); send(8'h22); send(8'h33);
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_load");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_exp(vecs[0].dout);
      send_block(vecs[0].din);
      recv_n(DIM, 1'b0, 1'b0);

      // Reset mid-UNLOAD after three outputs
      push_exp(vecs[0].dout);
      send_block(vecs[0].din);
      recv_n(3, 1'b0, 1'b0);
      check("mid_unload_busy", 32'(busy), 32'd1);
      exp_q.delete();
      out_idx = 0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_unload");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_exp(vecs[0].dout);
      send_block(vecs[0].din);
      recv_n(DIM, 1'b0, 1'b0);

      // Two blocks back-to-back
      n_in = 0;
      t_out_last = 0;
      push_exp(vecs[0].dout);
      push_exp(vecs[2].dout);
      fork
         begin
            send_block(vecs[0].din);
            send_block(vecs[2].din);
         end
         begin
            @(negedge clk);
            recv_n(2 * DIM, 1'b1, 1'b0);
         end
      join
      checks++;
      if (!(t_out_last != 0 && t_b_first > t_out_last)) begin
         errors++;
         $display("FAIL b2b_order: second block first input at %0t, first out_last transfer at %0t",
                  t_b_first, t_out_last);
      end
      check("b2b_q_empty", 32'(exp_q.size()), 32'd0);
      check_reset_outputs("idle_end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
